// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between fetch and the memory stage; the memory stage wins unless fetch has waited MAX_MEM_STREAK grants.
// Grant in IDLE -> mem_req next cycle -> ready pulse the cycle after ack; requesters hold their request until their pulse.
module mem_port_arbiter #(
  parameter int MAX_MEM_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        InstrReqF,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        InstrReadyF,

  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemReadyM,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,

  output logic        bus_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_F = 2'd1;
  localparam logic [1:0] S_BUSY_M = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int STREAK_W = $clog2(MAX_MEM_STREAK + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [STREAK_W-1:0] r_streak;
  logic [TMO_W-1:0]    r_tmo;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;

  logic [31:0]         r_instr;
  logic [31:0]         r_rdata;
  logic                r_instr_rdy;
  logic                r_mem_rdy;
  logic                r_bus_err;

  logic                w_idle;
  logic                w_busy_f;
  logic                w_busy_m;
  logic                w_busy;
  logic                w_grant_m;
  logic                w_grant_f;
  logic                w_ack;
  logic                w_tmo_exp;
  logic                w_finish;

  assign w_idle   = (r_state == S_IDLE);
  assign w_busy_f = (r_state == S_BUSY_F);
  assign w_busy_m = (r_state == S_BUSY_M);
  assign w_busy   = w_busy_f | w_busy_m;

  // The memory stage yields only once fetch has been passed over MAX_MEM_STREAK times in a row.
  assign w_grant_m = w_idle && MemReqM && (!InstrReqF || (r_streak < STREAK_MAX));
  assign w_grant_f = w_idle && !w_grant_m && InstrReqF;

  // An ack arriving on the last allowed cycle beats the timeout.
  assign w_ack     = w_busy && mem_ack;
  assign w_tmo_exp = w_busy && !mem_ack && (r_tmo == TMO_LAST);
  assign w_finish  = w_ack | w_tmo_exp;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_m) begin
          w_state_nxt = S_BUSY_M;
        end else if (w_grant_f) begin
          w_state_nxt = S_BUSY_F;
        end
      end
      S_BUSY_F, S_BUSY_M: begin
        if (w_finish) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else if (w_grant_m) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= MemWriteM;
      r_mem_addr  <= ALUOutM;
      r_mem_wdata <= WriteDataM;
    end else if (w_grant_f) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= PCF;
      r_mem_wdata <= 32'h0;
    end else if (w_finish) begin
      r_mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_idle) begin
      if (w_grant_f || !InstrReqF) begin
        r_streak <= '0;
      end else if (w_grant_m && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

  // Counts busy cycles that did not finish; any non-busy cycle (DONE, IDLE) leaves it at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (w_busy && !w_finish) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= 32'h0;
    end else if (w_busy_f && w_ack) begin
      r_instr <= mem_rdata;
    end else if (w_busy_f && w_tmo_exp) begin
      r_instr <= 32'h0;
    end
  end

  // Stores never touch the load-data register, whether they complete or time out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'h0;
    end else if (w_busy_m && !r_mem_we && w_ack) begin
      r_rdata <= mem_rdata;
    end else if (w_busy_m && !r_mem_we && w_tmo_exp) begin
      r_rdata <= 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_err <= 1'b0;
    end else if (w_tmo_exp) begin
      r_bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_rdy <= 1'b0;
      r_mem_rdy   <= 1'b0;
    end else begin
      r_instr_rdy <= w_busy_f && w_finish;
      r_mem_rdy   <= w_busy_m && w_finish;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign InstrF      = r_instr;
  assign ReadDataM   = r_rdata;
  assign InstrReadyF = r_instr_rdy;
  assign MemReadyM   = r_mem_rdy;
  assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios then random traffic, every cycle checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        InstrReqF;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        InstrReadyF;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemReadyM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_MEM_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .InstrReqF(InstrReqF), .PCF(PCF), .InstrF(InstrF), .InstrReadyF(InstrReadyF),
    .MemReqM(MemReqM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .MemReadyM(MemReadyM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory device contents; unwritten words return an address-derived pattern.
  logic [31:0] mem_m [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Transaction-level reference: one outstanding transaction, described by its cycle window.
  int          cyc       = 0;
  bit          m_busy    = 1'b0;
  bit          m_who_m   = 1'b0;
  bit          m_we      = 1'b0;
  logic [31:0] m_addr    = 32'h0;
  logic [31:0] m_wdata   = 32'h0;
  int          m_ack_at  = 0;
  int          m_end     = 0;
  int          m_free_at = 0;
  int          pulse_f_at = -1;
  int          pulse_m_at = -1;
  logic [31:0] e_instr   = 32'h0;
  logic [31:0] e_rdata   = 32'h0;
  bit          e_err     = 1'b0;
  int          streak    = 0;
  int          next_lat  = 0;
  bit          rand_lat  = 1'b0;
  bit          spur_en   = 1'b0;

  task automatic do_grant(input bit who_m, input logic [31:0] a, input bit we, input logic [31:0] wd);
    int lat;
    int r;
    m_busy  = 1'b1;
    m_who_m = who_m;
    m_addr  = a;
    m_we    = we;
    m_wdata = wd;
    if (rand_lat) begin
      r = $urandom_range(0, 19);
      if (r == 0)      lat = TMO + 3;
      else if (r == 1) lat = TMO - 1;
      else             lat = $urandom_range(0, 3);
    end else begin
      lat = next_lat;
    end
    m_ack_at = cyc + 1 + lat;
    m_end    = (lat <= TMO - 1) ? m_ack_at : cyc + TMO;
  endtask

  task automatic step();
    chk("mem_req", mem_req, m_busy);
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("InstrReadyF", InstrReadyF, cyc == pulse_f_at);
    chk("MemReadyM", MemReadyM, cyc == pulse_m_at);
    chk("InstrF", InstrF, e_instr);
    chk("ReadDataM", ReadDataM, e_rdata);
    chk("bus_err", bus_err, e_err);

    if (m_busy) begin
      mem_ack   = (cyc == m_ack_at);
      mem_rdata = mem_ack ? mem_rd(m_addr) : $urandom();
    end else begin
      mem_ack   = spur_en && ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom();
    end

    if (reset) begin
      m_busy = 1'b0; pulse_f_at = -1; pulse_m_at = -1;
      e_instr = 32'h0; e_rdata = 32'h0; e_err = 1'b0;
      streak = 0; m_free_at = cyc + 1;
    end else if (m_busy && cyc == m_end) begin
      if (m_ack_at == cyc) begin
        if (!m_who_m)  e_instr = mem_rd(m_addr);
        else if (m_we) mem_m[m_addr] = m_wdata;
        else           e_rdata = mem_rd(m_addr);
      end else begin
        e_err = 1'b1;
        if (!m_who_m)   e_instr = 32'h0;
        else if (!m_we) e_rdata = 32'h0;
      end
      if (m_who_m) pulse_m_at = cyc + 1;
      else         pulse_f_at = cyc + 1;
      m_busy    = 1'b0;
      m_free_at = cyc + 2;
    end else if (!m_busy && cyc >= m_free_at) begin
      if (MemReqM && (!InstrReqF || streak < MAXS)) begin
        do_grant(1'b1, ALUOutM, MemWriteM, WriteDataM);
        streak = InstrReqF ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
      end else if (InstrReqF) begin
        do_grant(1'b0, PCF, 1'b0, 32'h0);
        streak = 0;
      end else begin
        streak = 0;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_pulse_m();
    int n = 0;
    step();
    while (cyc != pulse_m_at && n < 60) begin step(); n++; end
    chk("MemReadyM_pulse", MemReadyM, 1'b1);
  endtask

  task automatic wait_pulse_f();
    int n = 0;
    step();
    while (cyc != pulse_f_at && n < 60) begin step(); n++; end
    chk("InstrReadyF_pulse", InstrReadyF, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hi;
    int          g;
    int          guard;
    logic [9:0]  order;
    logic        prev_req;
    bit          f_pend;
    bit          m_pend;
    bit          allow_new;

    reset = 1'b1; InstrReqF = 1'b0; PCF = 32'h0; MemReqM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = 32'h0; WriteDataM = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_InstrF", InstrF, 32'h0);
    chk("rst_ReadDataM", ReadDataM, 32'h0);
    chk("rst_InstrReadyF", InstrReadyF, 1'b0);
    chk("rst_MemReadyM", MemReadyM, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    reset = 1'b0;

    // Lone fetch with single-cycle ack
    mem_m[32'h40] = 32'h8C22_0004;
    next_lat = 0; InstrReqF = 1'b1; PCF = 32'h40;
    step();
    chk("fetch_req", mem_req, 1'b1);
    chk("fetch_addr", mem_addr, 32'h40);
    chk("fetch_we", mem_we, 1'b0);
    step();
    chk("fetch_rdy", InstrReadyF, 1'b1);
    chk("fetch_data", InstrF, 32'h8C22_0004);
    chk("fetch_mrdy", MemReadyM, 1'b0);
    InstrReqF = 1'b0;
    step();
    chk("fetch_req_drop", mem_req, 1'b0);

    // Store then load with three busy cycles each
    MemReqM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h100; WriteDataM = 32'hCAFE_F00D; next_lat = 2;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("st_req", mem_req, 1'b1);
      chk("st_we", mem_we, 1'b1);
      chk("st_wdata", mem_wdata, 32'hCAFE_F00D);
      step();
    end
    chk("st_rdy", MemReadyM, 1'b1);
    chk("st_rdata_hold", ReadDataM, 32'h0);
    MemWriteM = 1'b0;
    wait_pulse_m();
    chk("ld_data", ReadDataM, 32'hCAFE_F00D);
    MemReqM = 1'b0;
    step();

    // Ack on the final allowed busy cycle wins over the timeout
    mem_m[32'h200] = 32'h1234_5678;
    MemReqM = 1'b1; ALUOutM = 32'h200; next_lat = TMO - 1;
    wait_pulse_m();
    chk("late_ack_err", bus_err, 1'b0);
    chk("late_ack_data", ReadDataM, 32'h1234_5678);
    MemReqM = 1'b0;
    step();

    // No ack at all: abort after TMO busy cycles
    MemReqM = 1'b1; ALUOutM = 32'h300; next_lat = 1000;
    step();
    hi = 0;
    while (mem_req === 1'b1 && hi < 40) begin hi++; step(); end
    chk("tmo_busy_cycles", hi, TMO);
    chk("tmo_rdy", MemReadyM, 1'b1);
    chk("tmo_err", bus_err, 1'b1);
    chk("tmo_data", ReadDataM, 32'h0);
    MemReqM = 1'b0;
    repeat (3) step();
    chk("tmo_err_sticky", bus_err, 1'b1);

    // Continuous contention: fetch forced through after every MAXS memory grants
    spur_en = 1'b1;
    InstrReqF = 1'b1; PCF = 32'h1000; MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h2000; next_lat = 0;
    order = '0; g = 0; guard = 0; prev_req = 1'b0;
    while (g < 10 && guard < 200) begin
      step();
      guard++;
      if (mem_req === 1'b1 && prev_req !== 1'b1) begin
        order[g] = (mem_addr === 32'h1000);
        g++;
      end
      prev_req = mem_req;
    end
    chk("grant_order", order, 10'b10_0001_0000);
    InstrReqF = 1'b0; MemReqM = 1'b0;
    while (m_busy || cyc <= pulse_f_at || cyc <= pulse_m_at) step();
    step();

    // Reset in the middle of a busy transaction
    MemReqM = 1'b1; ALUOutM = 32'h400; next_lat = 1000;
    step();
    step();
    chk("mid_busy", mem_req, 1'b1);
    reset = 1'b1; MemReqM = 1'b0;
    step();
    reset = 1'b0;
    chk("mrst_req", mem_req, 1'b0);
    chk("mrst_addr", mem_addr, 32'h0);
    chk("mrst_we", mem_we, 1'b0);
    chk("mrst_wdata", mem_wdata, 32'h0);
    chk("mrst_err", bus_err, 1'b0);
    chk("mrst_mrdy", MemReadyM, 1'b0);
    repeat (3) step();
    mem_m[32'h500] = 32'hDEAD_BEEF;
    InstrReqF = 1'b1; PCF = 32'h500; next_lat = 1;
    wait_pulse_f();
    chk("post_rst_fetch", InstrF, 32'hDEAD_BEEF);
    InstrReqF = 1'b0;
    step();

    // Random traffic, then a drain where pending requests are held to completion
    rand_lat = 1'b1;
    f_pend = 1'b0; m_pend = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      allow_new = (i < 1500);
      if (f_pend && cyc == pulse_f_at) f_pend = 1'b0;
      if (m_pend && cyc == pulse_m_at) m_pend = 1'b0;
      if (allow_new && !f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1'b1;
        PCF = 32'h1000 + ($urandom_range(0, 15) << 2);
      end
      if (allow_new && !m_pend && $urandom_range(0, 1) == 0) begin
        m_pend = 1'b1;
        MemWriteM  = $urandom_range(0, 1);
        ALUOutM    = 32'h100 + ($urandom_range(0, 15) << 2);
        WriteDataM = $urandom();
      end
      InstrReqF = f_pend;
      MemReqM   = m_pend;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
